// File: rtl/pass_sequencer.sv
// pass_sequencer: per-layer pass/transfer sequencer driving forward/backward DMA, array pass and ofmap dump.
// Optional bias tile load on pass 0 when PASS_SEQ_BIAS_EN is defined.
module pass_sequencer #(
  parameter int WORDS_WIDTH = 16,
  parameter int PASS_WIDTH  = 8,
  parameter int TYPE_WIDTH  = 2
) (
  input  logic                   core_clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [PASS_WIDTH-1:0]  num_passes,
  input  logic [WORDS_WIDTH-1:0] filter_words,
  input  logic [WORDS_WIDTH-1:0] ifmap_words,
  input  logic [WORDS_WIDTH-1:0] psum_words,
  input  logic [WORDS_WIDTH-1:0] ofmap_words,
`ifdef PASS_SEQ_BIAS_EN
  input  logic [WORDS_WIDTH-1:0] bias_words,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [PASS_WIDTH-1:0]  pass_idx,
  output logic                   start_forward,
  output logic                   start_backward,
  output logic [TYPE_WIDTH-1:0]  transfer_type,
  output logic [WORDS_WIDTH-1:0] words_num,
  input  logic                   transfer_done,
  output logic                   start_pass,
  input  logic                   pass_done,
  output logic                   ofmap_dump,
  input  logic                   dump_done
);
  localparam logic [4:0] IDLE     = 5'd0;
  localparam logic [4:0] LD_FILT  = 5'd1;
  localparam logic [4:0] WT_FILT  = 5'd2;
  localparam logic [4:0] LD_IFMAP = 5'd3;
  localparam logic [4:0] WT_IFMAP = 5'd4;
  localparam logic [4:0] LD_PSUM  = 5'd5;
  localparam logic [4:0] WT_PSUM  = 5'd6;
  localparam logic [4:0] RUN      = 5'd7;
  localparam logic [4:0] WT_RUN   = 5'd8;
  localparam logic [4:0] DUMP     = 5'd9;
  localparam logic [4:0] WT_DUMP  = 5'd10;
  localparam logic [4:0] ST_BWD   = 5'd11;
  localparam logic [4:0] WT_BWD   = 5'd12;
  localparam logic [4:0] NEXT     = 5'd13;
  localparam logic [4:0] FIN      = 5'd14;
`ifdef PASS_SEQ_BIAS_EN
  localparam logic [4:0] LD_BIAS  = 5'd15;
  localparam logic [4:0] WT_BIAS  = 5'd16;
  localparam logic [4:0] PASS0_GO = LD_BIAS;
  logic [WORDS_WIDTH-1:0] bw;
`else
  localparam logic [4:0] PASS0_GO = RUN;
`endif
  logic [4:0] state;
  logic [PASS_WIDTH-1:0] np, nxt_idx;
  logic [WORDS_WIDTH-1:0] fw, iw, pw, ow;
  assign nxt_idx = pass_idx + PASS_WIDTH'(1);
  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass_idx       <= '0;
      start_forward  <= 1'b0;
      start_backward <= 1'b0;
      start_pass     <= 1'b0;
      ofmap_dump     <= 1'b0;
      transfer_type  <= '0;
      words_num      <= '0;
      np             <= '0;
      fw             <= '0;
      iw             <= '0;
      pw             <= '0;
      ow             <= '0;
`ifdef PASS_SEQ_BIAS_EN
      bw             <= '0;
`endif
    end else begin
      start_forward  <= 1'b0;
      start_backward <= 1'b0;
      start_pass     <= 1'b0;
      ofmap_dump     <= 1'b0;
      done           <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy     <= 1'b1;
          pass_idx <= '0;
          np       <= num_passes;
          fw       <= filter_words;
          iw       <= ifmap_words;
          pw       <= psum_words;
          ow       <= ofmap_words;
`ifdef PASS_SEQ_BIAS_EN
          bw       <= bias_words;
`endif
          state    <= (num_passes == '0) ? FIN : LD_FILT;
        end
        // Zero-length loads fall through to the next load without a request.
        LD_FILT: if (fw == '0) state <= LD_IFMAP;
        else begin
          start_forward <= 1'b1;
          transfer_type <= TYPE_WIDTH'(0);
          words_num     <= fw;
          state         <= WT_FILT;
        end
        WT_FILT:  if (transfer_done) state <= LD_IFMAP;
        LD_IFMAP: if (iw == '0) state <= LD_PSUM;
        else begin
          start_forward <= 1'b1;
          transfer_type <= TYPE_WIDTH'(1);
          words_num     <= iw;
          state         <= WT_IFMAP;
        end
        WT_IFMAP: if (transfer_done) state <= LD_PSUM;
        // Pass 0 has no prior partial sums; it instead visits the bias load when present.
        LD_PSUM: if (pass_idx == '0) state <= PASS0_GO;
        else if (pw == '0) state <= RUN;
        else begin
          start_forward <= 1'b1;
          transfer_type <= TYPE_WIDTH'(2);
          words_num     <= pw;
          state         <= WT_PSUM;
        end
        WT_PSUM: if (transfer_done) state <= RUN;
`ifdef PASS_SEQ_BIAS_EN
        LD_BIAS: if (bw == '0) state <= RUN;
        else begin
          start_forward <= 1'b1;
          transfer_type <= TYPE_WIDTH'(3);
          words_num     <= bw;
          state         <= WT_BIAS;
        end
        WT_BIAS: if (transfer_done) state <= RUN;
`endif
        RUN: begin
          start_pass <= 1'b1;
          state      <= WT_RUN;
        end
        WT_RUN: if (pass_done) state <= DUMP;
        DUMP: begin
          ofmap_dump <= 1'b1;
          state      <= WT_DUMP;
        end
        WT_DUMP: if (dump_done) state <= ST_BWD;
        ST_BWD: if (ow == '0) state <= NEXT;
        else begin
          start_backward <= 1'b1;
          transfer_type  <= TYPE_WIDTH'(2);
          words_num      <= ow;
          state          <= WT_BWD;
        end
        WT_BWD: if (transfer_done) state <= NEXT;
        NEXT: begin
          pass_idx <= nxt_idx;
          state    <= (nxt_idx == np) ? FIN : LD_FILT;
        end
        FIN: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          pass_idx <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pass_sequencer.sv
// tb_pass_sequencer: directed scenarios for pass_sequencer with a 3-cycle handshake responder.
module tb_pass_sequencer;
  logic core_clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [7:0] num_passes = '0;
  logic [15:0] filter_words = '0, ifmap_words = '0, psum_words = '0, ofmap_words = '0;
`ifdef PASS_SEQ_BIAS_EN
  logic [15:0] bias_words = '0;
`endif
  logic busy, done, start_forward, start_backward, start_pass, ofmap_dump;
  logic [7:0] pass_idx;
  logic [1:0] transfer_type;
  logic [15:0] words_num;
  logic transfer_done = 1'b0, pass_done = 1'b0, dump_done = 1'b0;
  int n_cmp = 0, n_err = 0;
  int q_type[$], q_words[$], q_idx[$], q_spass[$], q_bwd[$];
  int n_dump = 0, n_done = 0, spur_req = 0, spur_served = 0;
  pass_sequencer dut (
    .core_clk(core_clk), .reset(reset), .start(start), .num_passes(num_passes),
    .filter_words(filter_words), .ifmap_words(ifmap_words), .psum_words(psum_words),
    .ofmap_words(ofmap_words),
`ifdef PASS_SEQ_BIAS_EN
    .bias_words(bias_words),
`endif
    .busy(busy), .done(done), .pass_idx(pass_idx), .start_forward(start_forward),
    .start_backward(start_backward), .transfer_type(transfer_type), .words_num(words_num),
    .transfer_done(transfer_done), .start_pass(start_pass), .pass_done(pass_done),
    .ofmap_dump(ofmap_dump), .dump_done(dump_done)
  );
  always #5 core_clk = ~core_clk;
  // Responder: returns each done pulse 3 cycles after its request and logs every request.
  initial begin : responder
    int tc, pc, dc;
    tc = 0; pc = 0; dc = 0;
    forever begin
      @(posedge core_clk);
      #1;
      transfer_done = 1'b0; pass_done = 1'b0; dump_done = 1'b0;
      if (reset) begin
        tc = 0; pc = 0; dc = 0;
      end else begin
        if (tc > 0) begin tc--; if (tc == 0) transfer_done = 1'b1; end
        if (pc > 0) begin pc--; if (pc == 0) pass_done = 1'b1; end
        if (dc > 0) begin dc--; if (dc == 0) dump_done = 1'b1; end
        if (spur_req != spur_served) begin pass_done = 1'b1; spur_served++; end
        if (start_forward) begin
          q_type.push_back(int'(transfer_type)); q_words.push_back(int'(words_num));
          q_idx.push_back(int'(pass_idx)); tc = 3;
        end
        if (start_backward) begin q_bwd.push_back(int'(words_num)); tc = 3; end
        if (start_pass) begin q_spass.push_back(int'(pass_idx)); pc = 3; end
        if (ofmap_dump) begin n_dump++; dc = 3; end
        if (done) n_done++;
      end
    end
  end
  task automatic clear_log();
    q_type.delete(); q_words.delete(); q_idx.delete(); q_spass.delete(); q_bwd.delete();
    n_dump = 0; n_done = 0;
  endtask
  task automatic start_run(input int np, input int fw, input int iw, input int pw, input int ow);
    @(negedge core_clk);
    num_passes = 8'(np); filter_words = 16'(fw); ifmap_words = 16'(iw);
    psum_words = 16'(pw); ofmap_words = 16'(ow); start = 1'b1;
    @(negedge core_clk);
    start = 1'b0;
  endtask
  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    repeat (3000) begin
      @(negedge core_clk);
      if (done) begin timed_out = 1'b0; break; end
    end
  endtask
  task automatic test_reset();
    @(negedge core_clk);
    n_cmp++;
    if ({busy, done, start_forward, start_backward, start_pass, ofmap_dump, pass_idx, transfer_type, words_num} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got busy=%b done=%b idx=%0d type=%0d words=%0d, want all 0", busy, done, pass_idx, transfer_type, words_num);
    end
    reset = 1'b0;
  endtask
  task automatic test_single_pass();
    bit to;
    clear_log();
    @(negedge core_clk);
    num_passes = 8'd1; filter_words = 16'd12; ifmap_words = 16'd40; psum_words = 16'd16; ofmap_words = 16'd16;
    start = 1'b1;
    @(negedge core_clk);
    start = 1'b0;
    n_cmp++;
    if ({busy, start_forward} !== 2'b10) begin n_err++; $display("FAIL single_latency1: got busy=%b fwd=%b, want busy=1 fwd=0", busy, start_forward); end
    @(negedge core_clk);
    n_cmp++;
    if ({start_forward, transfer_type, words_num} !== {1'b1, 2'd0, 16'd12}) begin
      n_err++; $display("FAIL single_first_fwd: got fwd=%b type=%0d words=%0d, want 1/0/12", start_forward, transfer_type, words_num);
    end
    wait_done(to);
    n_cmp++;
    if (to !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL single_done: got timeout=%b busy=%b, want 0/0", to, busy); end
    n_cmp++;
    if (q_type.size() != 2 || q_type[0] != 0 || q_type[1] != 1 || q_words[1] != 40) begin
      n_err++; $display("FAIL single_fwd_seq: got %0d forwards, want types 0,1 words 12,40", q_type.size());
    end
    n_cmp++;
    if (q_spass.size() != 1 || n_dump != 1 || q_bwd.size() != 1 || q_bwd[0] != 16) begin
      n_err++; $display("FAIL single_counts: got pass=%0d dump=%0d bwd=%0d, want 1/1/1 with words 16", q_spass.size(), n_dump, q_bwd.size());
    end
    n_cmp++;
    if ({transfer_type, words_num} !== {2'd2, 16'd16}) begin
      n_err++; $display("FAIL single_hold: got type=%0d words=%0d, want 2/16", transfer_type, words_num);
    end
  endtask
  task automatic test_multi_pass();
    bit to;
    int et[8] = '{0, 1, 0, 1, 2, 0, 1, 2};
    int ew[8] = '{12, 40, 12, 40, 16, 12, 40, 16};
    int ei[8] = '{0, 0, 1, 1, 1, 2, 2, 2};
    clear_log();
    start_run(3, 12, 40, 16, 16);
    wait_done(to);
    n_cmp++;
    if (to !== 1'b0 || q_type.size() != 8) begin n_err++; $display("FAIL multi_fwd_count: got timeout=%b forwards=%0d, want 0/8", to, q_type.size()); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (i >= q_type.size() || q_type[i] != et[i] || q_words[i] != ew[i] || q_idx[i] != ei[i]) begin
        n_err++; $display("FAIL multi_fwd[%0d]: got type/words/idx mismatch or missing, want %0d/%0d/%0d", i, et[i], ew[i], ei[i]);
      end
    end
    n_cmp++;
    if (q_spass.size() != 3 || q_spass[0] != 0 || q_spass[1] != 1 || q_spass[2] != 2) begin
      n_err++; $display("FAIL multi_pass_idx: got %0d start_pass pulses, want idx 0,1,2", q_spass.size());
    end
    n_cmp++;
    if (q_bwd.size() != 3 || n_dump != 3 || n_done != 1 || pass_idx !== 8'd0) begin
      n_err++; $display("FAIL multi_counts: got bwd=%0d dump=%0d done=%0d idx=%0d, want 3/3/1/0", q_bwd.size(), n_dump, n_done, pass_idx);
    end
  endtask
  task automatic test_zero_passes();
    clear_log();
    start_run(0, 12, 40, 16, 16);
    n_cmp++;
    if ({done, busy} !== 2'b01) begin n_err++; $display("FAIL zero_cycle1: got done=%b busy=%b, want 0/1", done, busy); end
    @(negedge core_clk);
    n_cmp++;
    if ({done, busy} !== 2'b10) begin n_err++; $display("FAIL zero_cycle2: got done=%b busy=%b, want 1/0", done, busy); end
    repeat (3) @(negedge core_clk);
    n_cmp++;
    if (q_type.size() != 0 || q_spass.size() != 0 || q_bwd.size() != 0) begin
      n_err++; $display("FAIL zero_no_requests: got fwd=%0d pass=%0d bwd=%0d, want 0/0/0", q_type.size(), q_spass.size(), q_bwd.size());
    end
  endtask
  task automatic test_ifmap_zero();
    bit to;
    clear_log();
    start_run(1, 12, 0, 16, 16);
    wait_done(to);
    n_cmp++;
    if (to !== 1'b0 || q_type.size() != 1 || q_type[0] != 0 || q_spass.size() != 1) begin
      n_err++; $display("FAIL ifmap_zero: got timeout=%b fwd=%0d pass=%0d, want 0/1(type 0)/1", to, q_type.size(), q_spass.size());
    end
  endtask
  task automatic test_spurious();
    bit to, seen;
    clear_log();
    seen = 1'b0;
    start_run(1, 12, 40, 16, 16);
    repeat (20) begin
      @(negedge core_clk);
      if (start_forward) begin seen = 1'b1; break; end
    end
    spur_req++;
    @(negedge core_clk);
    @(negedge core_clk);
    num_passes = 8'd5; start = 1'b1;
    @(negedge core_clk);
    start = 1'b0;
    wait_done(to);
    n_cmp++;
    if (!seen || to !== 1'b0 || spur_served != spur_req) begin
      n_err++; $display("FAIL spur_flow: got seen=%b timeout=%b injected=%0d/%0d, want 1/0/equal", seen, to, spur_served, spur_req);
    end
    n_cmp++;
    if (q_type.size() != 2 || q_spass.size() != 1 || n_dump != 1 || q_bwd.size() != 1 || n_done != 1) begin
      n_err++; $display("FAIL spur_counts: got fwd=%0d pass=%0d dump=%0d bwd=%0d done=%0d, want 2/1/1/1/1", q_type.size(), q_spass.size(), n_dump, q_bwd.size(), n_done);
    end
    repeat (10) @(negedge core_clk);
    n_cmp++;
    if (busy !== 1'b0 || q_type.size() != 2) begin n_err++; $display("FAIL spur_no_restart: got busy=%b fwd=%0d, want 0/2", busy, q_type.size()); end
  endtask
  task automatic test_reset_mid();
    bit to, seen;
    clear_log();
    seen = 1'b0;
    start_run(2, 12, 40, 16, 16);
    repeat (100) begin
      @(negedge core_clk);
      if (start_pass) begin seen = 1'b1; break; end
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL rst_reach_run: got no start_pass, want one"); end
    reset = 1'b1; start = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, start_forward, start_backward, start_pass, ofmap_dump, pass_idx, transfer_type, words_num} !== '0) begin
      n_err++; $display("FAIL rst_mid_outputs: got busy=%b pass=%b idx=%0d type=%0d words=%0d, want all 0", busy, start_pass, pass_idx, transfer_type, words_num);
    end
    @(negedge core_clk);
    reset = 1'b0; start = 1'b0;
    @(negedge core_clk);
    n_cmp++;
    if ({busy, pass_idx} !== 9'd0) begin n_err++; $display("FAIL rst_start_ignored: got busy=%b idx=%0d, want 0/0", busy, pass_idx); end
    clear_log();
    start_run(1, 12, 40, 16, 16);
    wait_done(to);
    n_cmp++;
    if (to !== 1'b0 || q_type.size() != 2 || q_idx[0] != 0 || q_spass.size() != 1 || q_spass[0] != 0 || n_done != 1) begin
      n_err++; $display("FAIL rst_rerun: got timeout=%b fwd=%0d pass=%0d done=%0d, want 0/2/1/1 from pass 0", to, q_type.size(), q_spass.size(), n_done);
    end
  endtask
  initial begin
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_zero_passes();
    test_ifmap_zero();
    test_spurious();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pass_sequencer.md
Name: pass_sequencer

Overview:
- Top-level layer sequencer that drives the accelerator's pass/transfer handshake interface from a single start command.
- For each of N processing passes it:
  - loads filter, ifmap and (after the first pass) partial-sum tiles from DRAM into the GLB;
  - launches the pass;
  - dumps the ofmap from the array;
  - streams it back to DRAM.
- Sits between the host/testbench control registers and the accelerator core's start_pass / start_forward / start_backward control inputs.

Parameters:
- WORDS_WIDTH, 16, width of all word-count fields and words_num.
- PASS_WIDTH, 8, width of the pass counter and num_passes.
- TYPE_WIDTH, 2, width of transfer_type.

Ports:
- core_clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- num_passes  in  PASS_WIDTH  passes to run; sampled at start; 0 means finish immediately.
- filter_words, ifmap_words, psum_words, ofmap_words  in  WORDS_WIDTH each  per-pass transfer lengths; sampled at start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the last pass completes.
- pass_idx  out  PASS_WIDTH  index of the current pass.
- start_forward  out  1  one-cycle pulse; requests a DRAM→GLB transfer.
- start_backward  out  1  one-cycle pulse; requests a GLB→DRAM transfer.
- transfer_type  out  TYPE_WIDTH  transfer kind: 0 filter, 1 ifmap, 2 psum, 3 bias.
- words_num  out  WORDS_WIDTH  length of the current transfer.
- transfer_done  in  1  pulse; the current forward or backward transfer has finished.
- start_pass  out  1  one-cycle pulse; launches the array pass.
- pass_done  in  1  pulse; the array pass has finished.
- ofmap_dump  out  1  one-cycle pulse; dumps array psums to the GLB.
- dump_done  in  1  pulse; the dump has finished.

Behaviour:
- Reset state: all outputs are 0 and the FSM is in IDLE. Reset asserted mid-operation aborts immediately and discards every latched field.
- States:
  - IDLE → LD_FILT on start. If num_passes=0, go to FIN instead.
  - LD_FILT: pulse start_forward with type 0 and words_num=filter_words; → WT_FILT.
  - WT_FILT → LD_IFMAP on transfer_done.
  - LD_IFMAP: pulse start_forward with type 1; → WT_IFMAP.
  - WT_IFMAP → LD_PSUM on transfer_done.
  - LD_PSUM: taken only if pass_idx≠0; otherwise go straight to RUN. Pulses start_forward with type 2; → WT_PSUM.
  - WT_PSUM → RUN on transfer_done.
  - RUN: pulse start_pass; → WT_RUN.
  - WT_RUN → DUMP on pass_done.
  - DUMP: pulse ofmap_dump; → WT_DUMP.
  - WT_DUMP → ST_BWD on dump_done.
  - ST_BWD: pulse start_backward with words_num=ofmap_words and type 2; → WT_BWD.
  - WT_BWD → NEXT on transfer_done.
  - NEXT: increment pass_idx. If the new pass_idx equals the latched num_passes → FIN; else → LD_FILT.
  - FIN: pulse done, clear busy and pass_idx; → IDLE.
- Zero-length transfers: if a load's word count is 0, that LD/WT pair is skipped in the same cycle and no start_forward is issued. ofmap_words=0 skips ST_BWD/WT_BWD.
- Output timing:
  - All pulse outputs are registered and exactly one cycle wide.
  - transfer_type and words_num are registered. They become valid in the same cycle as the pulse and hold until the next transfer is issued.
- Latency: from start to the first start_forward pulse is 2 cycles (IDLE→LD_FILT register, then the pulse).
- Ignored inputs:
  - start while busy.
  - transfer_done, pass_done or dump_done arriving in any state other than its matching WT_* state. Such pulses are dropped, not queued.
- Counter arithmetic: pass_idx compares against the latched num_passes in PASS_WIDTH bits, so there is no wrap. With num_passes=255 the sequencer runs 255 passes.
- Simultaneous events: start in the same cycle as reset is ignored.

Optional Feature:
- Macro: PASS_SEQ_BIAS_EN.
- When defined:
  - An extra input bias_words [WORDS_WIDTH] is sampled at start.
  - On pass 0 only, states LD_BIAS/WT_BIAS run between WT_IFMAP and RUN. They issue start_forward with type 3 and words_num=bias_words.
  - A bias_words value of 0 skips these states.
- When undefined: the port and states do not exist and type 3 is never issued.

Test Plan:
- num_passes=1, filter/ifmap/psum/ofmap words=12/40/16/16, each done returned 3 cycles after its request → forward types 0,1 only (no psum on pass 0), one start_pass, one ofmap_dump, one start_backward with words 16, done pulse, busy low afterwards.
- num_passes=3 with the same counts → psum load (type 2, words 16) on passes 1 and 2 only; pass_idx steps 0,1,2; exactly 3 start_backward pulses, then done.
- num_passes=0 → done pulses 2 cycles after start; no start_forward, start_pass or start_backward.
- ifmap_words=0, num_passes=1 → only the type-0 forward is issued, then start_pass.
- Spurious pass_done while in WT_FILT, plus start re-asserted mid-run → both ignored; sequence and counts unchanged.
- Reset asserted while in WT_RUN → all outputs 0 immediately, FSM in IDLE; a new start then runs normally from pass 0.
